// File: rtl/evt_pkg.sv
// Shared event-path definitions: index/mask widths and typedefs used by both
// the priority-encoder side and the one-hot event decoder.
package evt_pkg;

  localparam int IDX_W     = 3;
  localparam int N         = 2 ** IDX_W;
  localparam int DUP_CNT_W = 8;

  typedef logic [IDX_W-1:0] evt_idx_t;
  typedef logic [N-1:0]     evt_mask_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational IDX_W-to-2**IDX_W one-hot decoder with enable; output is all
// zeros when en is low.
module onehot_dec #(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic                  en,
  output logic [2**IDX_W-1:0]   onehot
);

  localparam int N = 2 ** IDX_W;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/onehot_event_decoder.sv
// Decodes accepted event indices to one-hot strobes, tracks them in a pending
// bitmap cleared by ack, and flags/counts duplicates. ONEHOT_DEC_HOLD_EN makes
// dec_out hold the last accepted one-hot instead of pulsing.
module onehot_event_decoder
  import evt_pkg::*;
#(
  parameter int IDX_W     = evt_pkg::IDX_W,
  parameter int DUP_CNT_W = evt_pkg::DUP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2**IDX_W-1:0]   dec_out,
  output logic                  dec_valid,
  output logic [2**IDX_W-1:0]   pending,
  input  logic [2**IDX_W-1:0]   ack,
  output logic                  dup_err,
  output logic [DUP_CNT_W-1:0]  dup_cnt,
  input  logic                  err_clr
);

  localparam int NB = 2 ** IDX_W;

  logic [NB-1:0]        pending_reg, pending_next;
  logic [NB-1:0]        dec_out_reg, dec_out_next;
  logic                 dec_valid_reg;
  logic                 dup_err_reg, dup_err_next;
  logic [DUP_CNT_W-1:0] dup_cnt_reg, dup_cnt_next;
  logic [NB-1:0]        set_mask;
  logic                 accept;
  logic                 dup;

  // Full bitmap blocks new events unless some ack frees a slot this cycle.
  assign in_ready = !((&pending_reg) && !(|ack));
  assign accept   = in_valid && in_ready;

  onehot_dec #(.IDX_W(IDX_W)) u_dec (
    .idx    (in_idx),
    .en     (accept),
    .onehot (set_mask)
  );

  // A same-cycle ack of the bit makes the new event legitimate, not a duplicate.
  assign dup = |(set_mask & pending_reg & ~ack);

  always_comb begin
    pending_next = (pending_reg & ~ack) | set_mask;
`ifdef ONEHOT_DEC_HOLD_EN
    dec_out_next = accept ? set_mask : dec_out_reg;
`else
    dec_out_next = set_mask;
`endif
    dup_err_next = dup || (dup_err_reg && !err_clr);
    dup_cnt_next = dup_cnt_reg;
    if (dup) begin
      if (err_clr)
        dup_cnt_next = DUP_CNT_W'(1);
      else if (!(&dup_cnt_reg))
        dup_cnt_next = dup_cnt_reg + 1'b1;
    end else if (err_clr) begin
      dup_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      dec_out_reg   <= '0;
      dec_valid_reg <= 1'b0;
      dup_err_reg   <= 1'b0;
      dup_cnt_reg   <= '0;
    end else begin
      pending_reg   <= pending_next;
      dec_out_reg   <= dec_out_next;
      dec_valid_reg <= accept;
      dup_err_reg   <= dup_err_next;
      dup_cnt_reg   <= dup_cnt_next;
    end
  end

  assign pending   = pending_reg;
  assign dec_out   = dec_out_reg;
  assign dec_valid = dec_valid_reg;
  assign dup_err   = dup_err_reg;
  assign dup_cnt   = dup_cnt_reg;

endmodule

// File: tb/tb_onehot_event_decoder.sv
// Scoreboard bench for onehot_event_decoder: a behavioural model pushes the
// expected state per cycle, each test pops and compares after the clock edge.
module tb_onehot_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_idx;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dec_out;
  logic       dec_valid;
  logic [7:0] pending;
  logic [7:0] ack;
  logic       dup_err;
  logic [7:0] dup_cnt;
  logic       err_clr;

  onehot_event_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_idx    (in_idx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .pending   (pending),
    .ack       (ack),
    .dup_err   (dup_err),
    .dup_cnt   (dup_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [7:0] dout;
    logic       dv;
    logic [7:0] pend;
    logic       err;
    logic [7:0] cnt;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o, act_o;
  logic rdy_seen;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_dout = 8'h00;
  logic       m_dv   = 1'b0;
  logic       m_err  = 1'b0;
  logic [7:0] m_cnt  = 8'h00;

  // Drive one cycle of stimulus, predict the post-edge state, advance the clock.
  task automatic cyc(input logic r, input logic v, input logic [2:0] idx,
                     input logic [7:0] a, input logic ec);
    logic       m_rdy, acc, dupm;
    logic [7:0] setm;
    obs_t       e;
    rst = r; in_valid = v; in_idx = idx; ack = a; err_clr = ec;
    #1;
    rdy_seen = in_ready;
    m_rdy = !((m_pend == 8'hFF) && (a == 8'h00));
    acc   = v && m_rdy;
    setm  = acc ? (8'h01 << idx) : 8'h00;
    dupm  = acc && m_pend[idx] && !a[idx];
    if (r) begin
      m_pend = 8'h00; m_dout = 8'h00; m_dv = 1'b0; m_err = 1'b0; m_cnt = 8'h00;
    end else begin
      m_pend = (m_pend & ~a) | setm;
`ifdef ONEHOT_DEC_HOLD_EN
      if (acc) m_dout = setm;
`else
      m_dout = setm;
`endif
      m_dv = acc;
      if (dupm) begin
        m_err = 1'b1;
        m_cnt = ec ? 8'h01 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'h01);
      end else if (ec) begin
        m_err = 1'b0;
        m_cnt = 8'h00;
      end
    end
    e = '{rdy: m_rdy, dout: m_dout, dv: m_dv, pend: m_pend, err: m_err, cnt: m_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    act_o = '{rdy: rdy_seen, dout: dec_out, dv: dec_valid, pend: pending,
              err: dup_err, cnt: dup_cnt};
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      exp_o = sb.pop_front();
      checks++;
      if (act_o !== exp_o || act_o !== obs_t'({1'b1, 26'd0})) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got %h want %h", i, act_o, exp_o);
      end
    end
  endtask

  task automatic test_single();
    cyc(0, 1, 3'd5, 0, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || dec_out !== 8'h20 || pending !== 8'h20 || dec_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_idx5 got %h want %h", act_o, exp_o);
    end
    cyc(0, 0, 0, 0, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after got %h want %h", act_o, exp_o);
    end
    cyc(0, 0, 0, 8'h20, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || pending !== 8'h00) begin
      errors++;
      $display("FAIL single_ack got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_dup();
    cyc(0, 1, 3'd2, 0, 0);
    sb.delete();
    cyc(0, 1, 3'd2, 0, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || dup_err !== 1'b1 || dup_cnt !== 8'd1 || pending !== 8'h04) begin
      errors++;
      $display("FAIL dup_detect got %h want %h", act_o, exp_o);
    end
    cyc(0, 0, 0, 0, 1);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || dup_err !== 1'b0 || dup_cnt !== 8'd0) begin
      errors++;
      $display("FAIL dup_clear got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_ack_same();
    cyc(0, 1, 3'd2, 8'h04, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || pending !== 8'h04 || dup_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_same_cycle got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_full();
    cyc(1, 0, 0, 0, 0);
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 3'(i), 0, 0);
      exp_o = sb.pop_front();
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL fill_idx%0d got %h want %h", i, act_o, exp_o);
      end
    end
    cyc(0, 1, 3'd3, 0, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || act_o.rdy !== 1'b0 || pending !== 8'hFF || dec_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_block got %h want %h", act_o, exp_o);
    end
    cyc(0, 1, 3'd3, 8'h01, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || act_o.rdy !== 1'b1 || pending !== 8'hFE || dup_cnt !== 8'd1
        || dec_out !== 8'h08) begin
      errors++;
      $display("FAIL full_ack_dup got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_rst_mid();
    cyc(1, 1, 3'd6, 0, 0);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || {dec_out, dec_valid, pending, dup_err, dup_cnt} !== 26'd0) begin
      errors++;
      $display("FAIL rst_mid got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_saturation();
    cyc(0, 1, 3'd1, 0, 0);
    sb.delete();
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 3'd1, 0, 0);
      exp_o = sb.pop_front();
      if (i == 0 || i == 254 || i == 299) begin
        checks++;
        if (act_o !== exp_o) begin
          errors++;
          $display("FAIL sat_dup%0d got %h want %h", i, act_o, exp_o);
        end
      end
    end
    checks++;
    if (dup_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_value got %h want ff", dup_cnt);
    end
    cyc(0, 1, 3'd1, 0, 1);
    exp_o = sb.pop_front();
    checks++;
    if (act_o !== exp_o || dup_err !== 1'b1 || dup_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_vs_dup got %h want %h", act_o, exp_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc(0, 1'($urandom_range(0, 1)), 3'($urandom), a, ($urandom_range(0, 15) == 0));
      exp_o = sb.pop_front();
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL random_cyc%0d got %h want %h", i, act_o, exp_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0; ack = 8'h00; err_clr = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_dup();
    test_ack_same();
    test_full();
    test_rst_mid();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_event_decoder.md
Name: onehot_event_decoder

Overview:
- Inverse end of the 8-to-3 priority encoding path: accepts encoded event indices (index plus valid) and decodes each to a one-hot pulse.
- Accumulates decoded events in a pending bitmap that downstream logic clears per bit with acknowledges.
- Flags and counts duplicate events, i.e. an index arriving while its pending bit is still set.
- Sits between the encoder output and the per-channel service logic.

Parameters:
- IDX_W, 3, width of the encoded index; N = 2**IDX_W (8) is a derived local constant, not overridable.
- DUP_CNT_W, 8, width of the saturating duplicate-event counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset: synchronous, active-high
- in_idx  input  IDX_W  encoded event index
- in_valid  input  1  in_idx is valid this cycle
- in_ready  output  1  block can accept an event this cycle
- dec_out  output  N  registered one-hot of the last accepted index
- dec_valid  output  1  one-cycle strobe qualifying dec_out
- pending  output  N  outstanding event bitmap
- ack  input  N  per-bit clear of pending; multiple bits allowed
- dup_err  output  1  sticky duplicate-event flag
- dup_cnt  output  DUP_CNT_W  saturating duplicate count
- err_clr  input  1  clears dup_err and dup_cnt

Behaviour:
- Reset (rst=1 at a clk edge): dec_out=0, dec_valid=0, pending=0, dup_err=0, dup_cnt=0. Reset overrides all inputs, including an in-flight accept.
- in_ready = NOT (all pending bits set AND no ack bit set this cycle). Purely combinational from registered state and ack; never depends on in_valid.
- Accept occurs when in_valid AND in_ready at a clk edge.
- Latency 1: on the edge after accept, dec_out = 1<<in_idx and dec_valid=1 for exactly one cycle.
- With no accept, dec_valid=0 and dec_out returns to 0 (pulse mode).
- pending next-state per bit i = (pending[i] AND NOT ack[i]) OR set[i], where set = the decoded accept.
- Accept of i together with ack[i] in the same cycle: set wins, pending[i] stays 1. This is not a duplicate.
- Duplicate: accept of i while pending[i]=1 and ack[i]=0. pending[i] stays 1, dup_err is set the next cycle, dup_cnt increments by 1 and saturates at all-ones. dec_out/dec_valid still strobe normally.
- err_clr: dup_err and dup_cnt go to 0 next cycle. A duplicate in the same cycle as err_clr wins, giving dup_err=1 and dup_cnt=1.
- ack bits for already-clear pending bits have no effect.
- in_valid while in_ready=0: no accept, no state change, and the source must hold the event.
- All arithmetic is unsigned. in_idx is always within range since N = 2**IDX_W.

Optional Feature:
- Macro: ONEHOT_DEC_HOLD_EN.
- Defined: dec_out holds the last accepted one-hot until the next accept or reset. dec_valid still pulses once per accept.
- Undefined: pulse mode as described in Behaviour.

Decomposition:
- Shared package evt_pkg holds:
  - IDX_W and N constants
  - evt_idx_t (IDX_W bits) and evt_mask_t (N bits) typedefs
  - DUP_CNT_W default
- The same package is later reused by the priority-encoder side.
- One natural sub-module: onehot_dec, a combinational IDX_W-to-N decoder with enable. It is instantiated once for dec_out/set generation.

Test Plan:
- Reset then idle, in_valid=0 for 10 cycles -> all outputs 0 and in_ready=1 throughout.
- in_idx=5, in_valid=1 for one cycle -> next cycle dec_out=8'b0010_0000, dec_valid=1, pending=8'h20; following cycle dec_valid=0, dec_out=0 (pulse mode).
- Accept idx 2, then idx 2 again with ack=0 -> dup_err=1, dup_cnt=1, pending=8'h04. Then err_clr=1 -> dup_err=0, dup_cnt=0.
- pending=8'h04 with idx 2 accepted and ack=8'h04 in the same cycle -> pending stays 8'h04, dup_err stays 0.
- Accept idx 0..7 sequentially -> pending=8'hFF, in_ready=0. Then in_valid with idx 3 and ack=0 -> not accepted. Then ack=8'h01 -> in_ready=1 the same cycle, and the idx 3 accept is counted as a duplicate.
- Assert rst mid-stream with in_valid=1 -> all outputs 0 next cycle and no accept recorded. Separately, 300 duplicates -> dup_cnt saturates at 8'hFF.
